mem_wb_reg: RTL and testbench

//   MEM->WB pipeline register of the 5-stage RV32I core.
//   - Captures memory-stage results and control; presents them to the writeback stage.
//   - Feeds the 4:1 result mux (sel=ResultSrcW): d0 ALUResultW, d1 ReadDataW, d2 PCPlus4W, d3 ImmExtW.
//   - Supports stall, flush and bubble tracking.
//   - Maintains the retired-instruction counter that later backs the instret CSR.

---
 rtl/mem_wb_reg.sv | 83 ++++++++
 tb/tb_mem_wb_reg.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM->WB pipeline register with stall/flush, x0/bubble write suppression and retired-instruction counter
module mem_wb_reg #(
    parameter int WIDTH     = 32,
    parameter int RET_CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 StallW,
    input  logic                 FlushW,
    input  logic                 ValidM,
    input  logic [WIDTH-1:0]     ALUResultM,
    input  logic [WIDTH-1:0]     ReadDataM,
    input  logic [WIDTH-1:0]     PCPlus4M,
    input  logic [WIDTH-1:0]     ImmExtM,
    input  logic [4:0]           RdM,
    input  logic                 RegWriteM,
    input  logic [1:0]           ResultSrcM,
    output logic [WIDTH-1:0]     ALUResultW,
    output logic [WIDTH-1:0]     ReadDataW,
    output logic [WIDTH-1:0]     PCPlus4W,
    output logic [WIDTH-1:0]     ImmExtW,
    output logic [4:0]           RdW,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic                 ValidW,
    output logic [RET_CNT_W-1:0] InstRetW
);
    logic [WIDTH-1:0]     alu_result_q, alu_result_d;
    logic [WIDTH-1:0]     read_data_q, read_data_d;
    logic [WIDTH-1:0]     pc_plus4_q, pc_plus4_d;
    logic [WIDTH-1:0]     imm_ext_q, imm_ext_d;
    logic [4:0]           rd_q, rd_d;
    logic                 reg_write_q, reg_write_d;
    logic [1:0]           result_src_q, result_src_d;
    logic                 valid_q, valid_d;
    logic [RET_CNT_W-1:0] inst_ret_q, inst_ret_d;
    logic                 retire;
    always_comb begin
        alu_result_d = FlushW ? '0 : StallW ? alu_result_q : ALUResultM;
        read_data_d  = FlushW ? '0 : StallW ? read_data_q  : ReadDataM;
        pc_plus4_d   = FlushW ? '0 : StallW ? pc_plus4_q   : PCPlus4M;
        imm_ext_d    = FlushW ? '0 : StallW ? imm_ext_q    : ImmExtM;
        rd_d         = FlushW ? '0 : StallW ? rd_q         : RdM;
        result_src_d = FlushW ? '0 : StallW ? result_src_q : ResultSrcM;
        valid_d      = FlushW ? 1'b0 : StallW ? valid_q : ValidM;
        reg_write_d  = FlushW ? 1'b0 : StallW ? reg_write_q : (RegWriteM & ValidM & (RdM != 5'd0));
        // retirement depends only on the outgoing entry, so a flush still counts it
        retire       = valid_q & ~StallW;
        inst_ret_d   = inst_ret_q + {{(RET_CNT_W-1){1'b0}}, retire};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus4_q   <= '0;
            imm_ext_q    <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            valid_q      <= 1'b0;
            inst_ret_q   <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            pc_plus4_q   <= pc_plus4_d;
            imm_ext_q    <= imm_ext_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            valid_q      <= valid_d;
            inst_ret_q   <= inst_ret_d;
        end
    end
    assign ALUResultW = alu_result_q;
    assign ReadDataW  = read_data_q;
    assign PCPlus4W   = pc_plus4_q;
    assign ImmExtW    = imm_ext_q;
    assign RdW        = rd_q;
    assign RegWriteW  = reg_write_q;
    assign ResultSrcW = result_src_q;
    assign ValidW     = valid_q;
    assign InstRetW   = inst_ret_q;
endmodule

// File: tb/tb_mem_wb_reg.sv
// tb_mem_wb_reg: directed vector table plus reset, async-reset and counter-wrap sequences for mem_wb_reg
module tb_mem_wb_reg;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        StallW = 1'b0, FlushW = 1'b0, ValidM = 1'b0, RegWriteM = 1'b0;
    logic [31:0] ALUResultM = '0, ReadDataM = '0, PCPlus4M = '0, ImmExtM = '0;
    logic [4:0]  RdM = '0;
    logic [1:0]  ResultSrcM = '0;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ImmExtW;
    logic [4:0]  RdW;
    logic        RegWriteW, ValidW;
    logic [1:0]  ResultSrcW;
    logic [63:0] InstRetW;
    logic [31:0] s_alu, s_rdata, s_pc4, s_imm;
    logic [4:0]  s_rd;
    logic        s_rw, s_valid;
    logic [1:0]  s_src;
    logic [3:0]  s_cnt;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_reg #(.WIDTH(32), .RET_CNT_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
        .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ValidW(ValidW), .InstRetW(InstRetW)
    );

    mem_wb_reg #(.WIDTH(32), .RET_CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
        .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultW(s_alu), .ReadDataW(s_rdata), .PCPlus4W(s_pc4), .ImmExtW(s_imm),
        .RdW(s_rd), .RegWriteW(s_rw), .ResultSrcW(s_src), .ValidW(s_valid), .InstRetW(s_cnt)
    );

    typedef struct {
        logic        fl, st, vm, rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] alu, rdata, pc4, imm;
        logic        ev, erw;
        logic [4:0]  erd;
        logic [1:0]  esrc;
        logic [31:0] ealu, erdata, epc4, eimm;
        logic [63:0] ecnt;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic ev, input logic erw, input logic [4:0] erd,
                           input logic [1:0] esrc, input logic [31:0] ealu, input logic [31:0] erdata,
                           input logic [31:0] epc4, input logic [31:0] eimm, input logic [63:0] ecnt);
        check({tag, ".ValidW"}, 64'(ValidW), 64'(ev));
        check({tag, ".RegWriteW"}, 64'(RegWriteW), 64'(erw));
        check({tag, ".RdW"}, 64'(RdW), 64'(erd));
        check({tag, ".ResultSrcW"}, 64'(ResultSrcW), 64'(esrc));
        check({tag, ".ALUResultW"}, 64'(ALUResultW), 64'(ealu));
        check({tag, ".ReadDataW"}, 64'(ReadDataW), 64'(erdata));
        check({tag, ".PCPlus4W"}, 64'(PCPlus4W), 64'(epc4));
        check({tag, ".ImmExtW"}, 64'(ImmExtW), 64'(eimm));
        check({tag, ".InstRetW"}, InstRetW, ecnt);
    endtask

    task automatic drive(input logic fl, input logic st, input logic vm, input logic rw, input logic [4:0] rd,
                         input logic [1:0] src, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [31:0] imm);
        FlushW = fl; StallW = st; ValidM = vm; RegWriteM = rw; RdM = rd; ResultSrcM = src;
        ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4; ImmExtM = imm;
    endtask

    initial begin
        //           fl st vm rw rd  src alu           rdata         pc4         imm           | ev erw erd src ealu         erdata        epc4        eimm          cnt
        vecs[0]  = '{0, 0, 1, 1, 5,  0, 32'h1234,     32'hAAAA,     32'h100, 32'h0,        1, 1, 5,  0, 32'h1234,     32'hAAAA,     32'h100, 32'h0,        64'd0};
        vecs[1]  = '{0, 0, 1, 1, 0,  1, 32'h2222,     32'hBEEF,     32'h104, 32'h7,        1, 0, 0,  1, 32'h2222,     32'hBEEF,     32'h104, 32'h7,        64'd1};
        vecs[2]  = '{0, 0, 0, 1, 3,  2, 32'h3333,     32'h0,        32'h108, 32'h0,        0, 0, 3,  2, 32'h3333,     32'h0,        32'h108, 32'h0,        64'd2};
        vecs[3]  = '{0, 0, 1, 1, 7,  3, 32'h0,        32'h0,        32'h104, 32'hDEAD,     1, 1, 7,  3, 32'h0,        32'h0,        32'h104, 32'hDEAD,     64'd2};
        vecs[4]  = '{0, 1, 1, 1, 9,  0, 32'h5,        32'h6,        32'h200, 32'h1,        1, 1, 7,  3, 32'h0,        32'h0,        32'h104, 32'hDEAD,     64'd2};
        vecs[5]  = '{0, 1, 0, 0, 2,  1, 32'h55,       32'h66,       32'h204, 32'h2,        1, 1, 7,  3, 32'h0,        32'h0,        32'h104, 32'hDEAD,     64'd2};
        vecs[6]  = '{0, 1, 1, 0, 12, 2, 32'h555,      32'h666,      32'h208, 32'h3,        1, 1, 7,  3, 32'h0,        32'h0,        32'h104, 32'hDEAD,     64'd2};
        vecs[7]  = '{1, 1, 1, 1, 8,  2, 32'h77,       32'h88,       32'h20C, 32'h4,        0, 0, 0,  0, 32'h0,        32'h0,        32'h0,   32'h0,        64'd2};
        vecs[8]  = '{0, 0, 1, 1, 31, 2, 32'hFFFFFFFF, 32'h12345678, 32'h300, 32'hABC,      1, 1, 31, 2, 32'hFFFFFFFF, 32'h12345678, 32'h300, 32'hABC,      64'd2};
        vecs[9]  = '{1, 0, 1, 1, 6,  1, 32'h11,       32'h22,       32'h304, 32'h33,       0, 0, 0,  0, 32'h0,        32'h0,        32'h0,   32'h0,        64'd3};
        vecs[10] = '{1, 0, 1, 1, 6,  1, 32'h11,       32'h22,       32'h308, 32'h33,       0, 0, 0,  0, 32'h0,        32'h0,        32'h0,   32'h0,        64'd3};
        vecs[11] = '{0, 0, 1, 0, 4,  1, 32'h6,        32'h0,        32'h400, 32'h0,        1, 0, 4,  1, 32'h6,        32'h0,        32'h400, 32'h0,        64'd3};
        vecs[12] = '{0, 1, 0, 1, 1,  3, 32'h99,       32'h98,       32'h404, 32'h97,       1, 0, 4,  1, 32'h6,        32'h0,        32'h400, 32'h0,        64'd3};
        vecs[13] = '{0, 0, 0, 0, 0,  0, 32'h0,        32'h0,        32'h0,   32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        32'h0,   32'h0,        64'd4};

        // reset held with random inputs while the clock runs
        repeat (3) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom),
                  $urandom, $urandom, $urandom, $urandom);
            @(posedge clk); #1;
        end
        check_w("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 64'd0);
        check("rst_hold.small_cnt", 64'(s_cnt), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_w("rst_release", 0, 0, 0, 0, 0, 0, 0, 0, 64'd0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].fl, vecs[i].st, vecs[i].vm, vecs[i].rw, vecs[i].rd, vecs[i].src,
                  vecs[i].alu, vecs[i].rdata, vecs[i].pc4, vecs[i].imm);
            @(posedge clk); #1;
            check_w($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erw, vecs[i].erd, vecs[i].esrc,
                    vecs[i].ealu, vecs[i].erdata, vecs[i].epc4, vecs[i].eimm, vecs[i].ecnt);
        end

        // asynchronous reset in mid-cycle discards a valid W entry without counting it
        drive(0, 0, 1, 1, 10, 2, 32'hCAFE, 32'hF00D, 32'h500, 32'h9);
        @(posedge clk); #1;
        check_w("pre_async", 1, 1, 10, 2, 32'hCAFE, 32'hF00D, 32'h500, 32'h9, 64'd4);
        reset_n = 1'b0;
        #1;
        check_w("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 64'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_w("post_async", 0, 0, 0, 0, 0, 0, 0, 0, 64'd0);

        // 17 valid captures: 16 retires, the 4-bit counter ends 15 -> 0
        drive(0, 0, 1, 1, 1, 0, 32'h1, 32'h0, 32'h0, 32'h0);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            check($sformatf("wrap%0d.small", k), 64'(s_cnt), 64'((k - 1) % 16));
            check($sformatf("wrap%0d.wide", k), InstRetW, 64'(k - 1));
        end
        check("wrap.final", 64'(s_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
